// File: rtl/dfconv_job_dispatch.sv
// dfconv_job_dispatch -- layer-descriptor FIFO and job issuer for the dfconv engine.
//
// Buffers {rows, cols, in_ch, out_ch} descriptors in a DEPTH-entry FIFO and
// hands them to the engine one at a time over start/busy/done. Completed jobs
// feed a saturating cycle total and a wrapping job counter.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   job_valid/job_ready, job_*      descriptor push (ready = FIFO not full)
//   eng_start, eng_*                one-cycle start pulse + descriptor, held until next issue
//   eng_busy, eng_done, eng_cycles  engine status and per-job cycle report
//   clear                           synchronous clear of total_cycles / jobs_done
//   total_cycles, jobs_done         run statistics
//   fifo_level, idle                occupancy and quiescence decode
//   timeout_err                     sticky watchdog flag
//
// Optional build macro JOB_TIMEOUT_EN: enables the WAIT watchdog
// (TIMEOUT_CYCLES). Without it WAIT never times out and timeout_err is 0.
module dfconv_job_dispatch #(
  parameter int WIDTH          = 16,
  parameter int ACC_WIDTH      = 32,
  parameter int DEPTH          = 4,
  parameter int TOT_WIDTH      = 48,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [WIDTH-1:0]           job_rows,
  input  logic [WIDTH-1:0]           job_cols,
  input  logic [WIDTH-1:0]           job_in_ch,
  input  logic [WIDTH-1:0]           job_out_ch,
  output logic                       eng_start,
  output logic [WIDTH-1:0]           eng_rows,
  output logic [WIDTH-1:0]           eng_cols,
  output logic [WIDTH-1:0]           eng_in_ch,
  output logic [WIDTH-1:0]           eng_out_ch,
  input  logic                       eng_busy,
  input  logic                       eng_done,
  input  logic [ACC_WIDTH-1:0]       eng_cycles,
  input  logic                       clear,
  output logic [TOT_WIDTH-1:0]       total_cycles,
  output logic [15:0]                jobs_done,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       idle,
  output logic                       timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [4*WIDTH-1:0] mem [DEPTH];
  logic [4*WIDTH-1:0] head;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic [1:0]         state;
  logic               push, pop, done_acc, tmo_hit;

  assign job_ready  = (count != (AW+1)'(DEPTH));
  assign fifo_level = count;
  assign idle       = (state == S_IDLE) && (count == '0);
  assign push       = job_valid && job_ready;
  assign pop        = (state == S_ISSUE);
  assign done_acc   = (state == S_WAIT) && eng_done;
  assign head       = mem[rd_ptr];

  // ---------------- descriptor FIFO ----------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {job_rows, job_cols, job_in_ch, job_out_ch};
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- watchdog ----------------
`ifdef JOB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wait_cnt;

  // Counts completed WAIT cycles; the TIMEOUT_CYCLES-th one without done aborts.
  assign tmo_hit = (state == S_WAIT) && !eng_done && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_ISSUE)                  wait_cnt <= '0;
      else if (state == S_WAIT && !eng_done) wait_cnt <= wait_cnt + 1'b1;
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // ---------------- issue FSM ----------------
  // Descriptor and start pulse are loaded on the IDLE->ISSUE edge so both
  // are visible together during the single ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      eng_start  <= 1'b0;
      eng_rows   <= '0;
      eng_cols   <= '0;
      eng_in_ch  <= '0;
      eng_out_ch <= '0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        S_IDLE: if (count != '0 && !eng_busy) begin
          state     <= S_ISSUE;
          eng_start <= 1'b1;
          {eng_rows, eng_cols, eng_in_ch, eng_out_ch} <= head;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT:  if (eng_done || tmo_hit) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------- statistics ----------------
  // clear acts first, so a clear coinciding with a done leaves just that job.
  logic [TOT_WIDTH-1:0] tot_base;
  logic [15:0]          jobs_base;
  logic [TOT_WIDTH:0]   tot_sum;

  assign tot_base  = clear ? '0 : total_cycles;
  assign jobs_base = clear ? '0 : jobs_done;
  assign tot_sum   = {1'b0, tot_base} + (TOT_WIDTH+1)'(eng_cycles);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_cycles <= '0;
      jobs_done    <= '0;
    end else if (done_acc) begin
      total_cycles <= tot_sum[TOT_WIDTH] ? '1 : tot_sum[TOT_WIDTH-1:0];
      jobs_done    <= jobs_base + 16'd1;
    end else if (clear) begin
      total_cycles <= '0;
      jobs_done    <= '0;
    end
  end

endmodule
